// File: rtl/button_pkg.sv
// Shared definitions for the display-board button path: bit map, consumer struct, channel states.
package button_pkg;

    // Bit positions in the raw/debounced button vector, LSB first.
    localparam int unsigned TEMP_ALARM  = 0;
    localparam int unsigned DIALL_CLICK = 1;
    localparam int unsigned DIALR_CLICK = 2;
    localparam int unsigned NAV_CLICK   = 3;
    localparam int unsigned NAV_D       = 4;
    localparam int unsigned NAV_R       = 5;
    localparam int unsigned NAV_L       = 6;
    localparam int unsigned NAV_U       = 7;
    localparam int unsigned SPARE2      = 8;
    localparam int unsigned SPARE1      = 9;
    localparam int unsigned TOUCH_IRQ   = 10;
    localparam int unsigned SPARE0      = 11;
    localparam int unsigned BUTTON_X    = 12;
    localparam int unsigned BUTTON_Y    = 13;
    localparam int unsigned BUTTON_A    = 14;
    localparam int unsigned BUTTON_B    = 15;

    // Named view of a 16-bit button vector; first field is the MSB.
    typedef struct packed {
        logic button_b;
        logic button_a;
        logic button_y;
        logic button_x;
        logic spare0;
        logic touch_irq;
        logic spare1;
        logic spare2;
        logic nav_u;
        logic nav_l;
        logic nav_r;
        logic nav_d;
        logic nav_click;
        logic dialr_click;
        logic diall_click;
        logic temp_alarm;
    } button_vec_t;

    typedef enum logic {
        StReleased,
        StPressed
    } chan_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-button debouncer: qualifies state changes over STABLE_SAMPLES ticks and
// tracks hold time for a one-shot long-press pulse.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned LONG_SAMPLES   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic s,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned HW = $clog2(LONG_SAMPLES + 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);
    localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_SAMPLES);

    chan_state_e   state_q, state_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    // State, counters and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StReleased;
            stable_q  <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // Next-state: qualification counter, hold counter and pulse requests.
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick) begin
            // Hold time accrues on every tick while pressed, saturating at LONG_MAX.
            if (state_q == StPressed && hold_q != LONG_MAX) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == LONG_MAX - 1'b1);
            end
            if (s != (state_q == StPressed)) begin
                if (stable_q == STABLE_LAST) begin
                    // Acceptance overrides the hold update, so long and release never coincide.
                    stable_d = '0;
                    hold_d   = '0;
                    long_d   = 1'b0;
                    unique case (state_q)
                        StPressed: begin
                            state_d   = StReleased;
                            release_d = 1'b1;
                        end
                        StReleased: begin
                            state_d = StPressed;
                            press_d = 1'b1;
                        end
                        default: state_d = StReleased;
                    endcase
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end else begin
                // Any sample agreeing with the current level restarts qualification.
                stable_d = '0;
            end
        end
    end

    assign pressed       = (state_q == StPressed);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/button_event_filter.sv
// Button event filter: synchronises the raw vector, generates the debounce sample
// tick and runs one debounce channel per button.
module button_event_filter
    import button_pkg::*;
#(
    parameter int unsigned N_BUTTONS      = 16,
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned SAMPLE_HZ      = 1000,
    parameter int unsigned STABLE_SAMPLES = 8,
    parameter int unsigned LONG_SAMPLES   = 1000,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] long_pulse,
    output logic                 any_event
);

    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned TW  = $clog2(DIV + 1);
    localparam logic [TW-1:0]        TICK_LAST = TW'(DIV - 1);
    localparam logic [N_BUTTONS-1:0] INACTIVE  = {N_BUTTONS{ACTIVE_LOW}};

    logic [TW-1:0]        tick_cnt_q;
    logic                 tick;
    logic [N_BUTTONS-1:0] sync1_q, sync2_q;
    logic [N_BUTTONS-1:0] s;

    // Sample-rate divider counting 0..DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    assign tick = (tick_cnt_q == TICK_LAST);

    // Two-flop synchroniser; reset to the released level so no false press is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= INACTIVE;
            sync2_q <= INACTIVE;
        end else begin
            sync1_q <= buttons_raw;
            sync2_q <= sync1_q;
        end
    end

    // Normalised so that 1 always means pressed.
    assign s = sync2_q ^ INACTIVE;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .LONG_SAMPLES   (LONG_SAMPLES)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .tick           (tick),
            .s              (s[i]),
            .pressed        (pressed[i]),
            .press_pulse    (press_pulse[i]),
            .release_pulse  (release_pulse[i]),
            .long_pulse     (long_pulse[i])
        );
    end

    assign any_event = |{press_pulse, release_pulse, long_pulse};

endmodule

// File: tb/tb_button_event_filter.sv
// Directed bench for button_event_filter with DIV=10, STABLE_SAMPLES=4, LONG_SAMPLES=20.
// Timeline: cyc counts clock edges since the first reset release; tick edges fall on
// multiples of 10 until the mid-run reset at cyc 886 shifts them to 896, 906, ...
module tb_button_event_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] buttons_raw;
    logic [15:0] pressed, press_pulse, release_pulse, long_pulse;
    logic        any_event;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int          press_cnt [16];
    int          rel_cnt   [16];
    int          long_cnt  [16];
    int          press_at  [16];
    int          rel_at    [16];
    int          long_at   [16];
    int          any_cnt;
    int          any_at;
    logic [15:0] press_vec;
    logic [15:0] rel_vec;

    button_event_filter #(
        .N_BUTTONS      (16),
        .CLK_HZ         (100),
        .SAMPLE_HZ      (10),
        .STABLE_SAMPLES (4),
        .LONG_SAMPLES   (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .buttons_raw    (buttons_raw),
        .pressed        (pressed),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse),
        .long_pulse     (long_pulse),
        .any_event      (any_event)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        for (int i = 0; i < 16; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_at[i]  = -1; rel_at[i] = -1; long_at[i] = -1;
        end
        any_cnt   = 0;
        any_at    = -1;
        press_vec = '0;
        rel_vec   = '0;
    endtask

    // Advance to edge number target, sampling 1 time unit after each edge.
    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 16; i++) begin
                if (press_pulse[i] === 1'b1) begin
                    if (press_cnt[i] == 0) press_at[i] = cyc;
                    press_cnt[i]++;
                end
                if (release_pulse[i] === 1'b1) begin
                    if (rel_cnt[i] == 0) rel_at[i] = cyc;
                    rel_cnt[i]++;
                end
                if (long_pulse[i] === 1'b1) begin
                    if (long_cnt[i] == 0) long_at[i] = cyc;
                    long_cnt[i]++;
                end
            end
            if (any_event === 1'b1) begin
                if (any_cnt == 0) any_at = cyc;
                any_cnt++;
            end
            if (press_vec == '0 && press_pulse != '0) press_vec = press_pulse;
            if (rel_vec == '0 && release_pulse != '0) rel_vec = release_pulse;
        end
    endtask

    task automatic test_reset();
        int total;
        rst = 1'b1;
        buttons_raw = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pressed, press_pulse, release_pulse, long_pulse, any_event} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%h/%h/%h/%b required all 0",
                     pressed, press_pulse, release_pulse, long_pulse, any_event);
        end
        rst = 1'b0;
        cyc = 0;
        clear_counts();
        step_to(200);
        total = 0;
        for (int i = 0; i < 16; i++) total += press_cnt[i] + rel_cnt[i] + long_cnt[i];
        vectors++;
        if (total != 0 || any_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_idle_pulses: got %0d pulses %0d any_event, required 0 and 0",
                     total, any_cnt);
        end
        vectors++;
        if (pressed !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_idle_pressed: got %h required 0000", pressed);
        end
    endtask

    task automatic test_clean_press();
        // raw[2] low at 200; sync 202; ticks 210,220,230,240 -> press seen at 240.
        clear_counts();
        buttons_raw[2] = 1'b0;
        step_to(243);
        vectors++;
        if (press_cnt[2] != 1 || press_at[2] != 240) begin
            miscompares++;
            $display("FAIL clean_press: got %0d pulses at cyc %0d, required 1 at 240",
                     press_cnt[2], press_at[2]);
        end
        vectors++;
        if (any_cnt != 1 || any_at != 240) begin
            miscompares++;
            $display("FAIL clean_any_event: got %0d at cyc %0d, required 1 at 240",
                     any_cnt, any_at);
        end
        vectors++;
        if (pressed !== 16'h0004 || press_vec !== 16'h0004) begin
            miscompares++;
            $display("FAIL clean_pressed: got level %h pulse %h, required 0004 and 0004",
                     pressed, press_vec);
        end
    endtask

    task automatic test_long_and_release();
        // Hold from acceptance at 240: 20th tick is 440. Raw release at 495 -> ticks
        // 500..530, release seen at 530.
        clear_counts();
        step_to(495);
        vectors++;
        if (pressed !== 16'h0004) begin
            miscompares++;
            $display("FAIL long_held_level: got %h required 0004", pressed);
        end
        buttons_raw[2] = 1'b1;
        step_to(545);
        vectors++;
        if (long_cnt[2] != 1 || long_at[2] != 440) begin
            miscompares++;
            $display("FAIL long_pulse: got %0d pulses at cyc %0d, required 1 at 440",
                     long_cnt[2], long_at[2]);
        end
        vectors++;
        if (rel_cnt[2] != 1 || rel_at[2] != 530) begin
            miscompares++;
            $display("FAIL release_pulse: got %0d pulses at cyc %0d, required 1 at 530",
                     rel_cnt[2], rel_at[2]);
        end
        vectors++;
        if (press_cnt[2] != 0 || any_cnt != 2 || pressed !== 16'h0000) begin
            miscompares++;
            $display("FAIL long_release_misc: got press %0d any %0d level %h, required 0 2 0000",
                     press_cnt[2], any_cnt, pressed);
        end
    endtask

    task automatic test_bounce();
        // Toggle every 15 cycles from 545 to 665; at most 2 agreeing ticks per low phase.
        clear_counts();
        for (int k = 0; k < 8; k++) begin
            buttons_raw[2] = (k % 2 == 0) ? 1'b0 : 1'b1;
            step_to(545 + 15 * (k + 1));
        end
        vectors++;
        if (press_cnt[2] != 0 || any_cnt != 0) begin
            miscompares++;
            $display("FAIL bounce_no_press: got %0d presses %0d events, required 0 and 0",
                     press_cnt[2], any_cnt);
        end
        // Settled low at 665; sync 667; ticks 670..700.
        buttons_raw[2] = 1'b0;
        step_to(715);
        vectors++;
        if (press_cnt[2] != 1 || press_at[2] != 700) begin
            miscompares++;
            $display("FAIL bounce_settle_press: got %0d pulses at cyc %0d, required 1 at 700",
                     press_cnt[2], press_at[2]);
        end
        // Release again at 715 -> ticks 720..750.
        clear_counts();
        buttons_raw[2] = 1'b1;
        step_to(760);
        vectors++;
        if (rel_cnt[2] != 1 || rel_at[2] != 750 || long_cnt[2] != 0 || pressed !== 16'h0000) begin
            miscompares++;
            $display("FAIL bounce_release: got %0d at %0d long %0d level %h, required 1 750 0 0000",
                     rel_cnt[2], rel_at[2], long_cnt[2], pressed);
        end
    endtask

    task automatic test_simultaneous();
        // raw[0] and raw[15] low at 760 -> press at 800; release at 815 -> 850.
        clear_counts();
        buttons_raw = 16'h7FFE;
        step_to(815);
        vectors++;
        if (press_vec !== 16'h8001 || press_at[0] != 800 || press_at[15] != 800) begin
            miscompares++;
            $display("FAIL simul_press: got %h at %0d/%0d, required 8001 at 800/800",
                     press_vec, press_at[0], press_at[15]);
        end
        vectors++;
        if (pressed !== 16'h8001 || any_cnt != 1 || press_cnt[0] != 1 || press_cnt[15] != 1) begin
            miscompares++;
            $display("FAIL simul_level: got %h any %0d, required 8001 any 1", pressed, any_cnt);
        end
        clear_counts();
        buttons_raw = 16'hFFFF;
        step_to(860);
        vectors++;
        if (rel_vec !== 16'h8001 || rel_at[0] != 850 || pressed !== 16'h0000) begin
            miscompares++;
            $display("FAIL simul_release: got %h at %0d level %h, required 8001 at 850 0000",
                     rel_vec, rel_at[0], pressed);
        end
    endtask

    task automatic test_reset_mid();
        // raw[1] low at 860; ticks 870,880 count; rst sampled at edge 886.
        // Post-reset ticks 896,906,916,926 -> press at 926 (890/900 without reset).
        clear_counts();
        buttons_raw[1] = 1'b0;
        step_to(885);
        rst = 1'b1;
        step_to(886);
        rst = 1'b0;
        vectors++;
        if ({pressed, press_pulse, any_event} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h/%h/%b required 0", pressed, press_pulse,
                     any_event);
        end
        step_to(940);
        vectors++;
        if (press_cnt[1] != 1 || press_at[1] != 926) begin
            miscompares++;
            $display("FAIL midreset_press: got %0d pulses at cyc %0d, required 1 at 926",
                     press_cnt[1], press_at[1]);
        end
        vectors++;
        if (pressed !== 16'h0002 || any_cnt != 1) begin
            miscompares++;
            $display("FAIL midreset_level: got %h any %0d, required 0002 any 1", pressed, any_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_long_and_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
